// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide execution unit.
//
// One operation in flight. A request is accepted in IDLE on a rising edge with start=1,
// spends 32 edges in CALC (one bit per edge) and one edge in FIX, so done pulses in the
// cycle after the 33rd edge following acceptance, independent of funct3 or operand values.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start, abort        request / kill in-flight operation
//   funct3              000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                       100 DIV, 101 DIVU, 110 REM, 111 REMU
//   Read_data1          rs1 (multiplicand / dividend)
//   Read_data2          rs2 (multiplier / divisor)
//   Rd_in               destination register of the request
//   busy                operation in flight
//   done                one-cycle result-valid pulse
//   Result, Rd_out      registered result and its destination tag (held until next done)
//   RegWrite_out        register-file write enable, identical to done
module mul_div_unit #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [2:0]                funct3,
    input  logic [DATA_WIDTH-1:0]     Read_data1,
    input  logic [DATA_WIDTH-1:0]     Read_data2,
    input  logic [REG_ADDR_WIDTH-1:0] Rd_in,
    output logic                      busy,
    output logic                      done,
    output logic [DATA_WIDTH-1:0]     Result,
    output logic [REG_ADDR_WIDTH-1:0] Rd_out,
    output logic                      RegWrite_out
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH - 1);
    localparam int unsigned Msb = DATA_WIDTH - 1;

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e                    state_q, state_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic [2:0]                op_q, op_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    // opa holds the multiplicand for multiplies and the divisor for divides.
    logic [DATA_WIDTH-1:0]     opa_q, opa_d;
    // {hi, lo}: product accumulator / multiplier for multiplies,
    // remainder / dividend-becoming-quotient for divides.
    logic [DATA_WIDTH-1:0]     hi_q, hi_d;
    logic [DATA_WIDTH-1:0]     lo_q, lo_d;
    logic                      neg_q, neg_d;          // product or quotient negative
    logic                      rem_neg_q, rem_neg_d;  // remainder follows dividend sign
    logic                      div_zero_q, div_zero_d;
    logic [DATA_WIDTH-1:0]     result_q, result_d;
    logic [REG_ADDR_WIDTH-1:0] rd_out_q, rd_out_d;
    logic                      done_q, done_d;

    // Operand preparation for a new request.
    logic                  is_div;
    logic                  a_signed, b_signed;
    logic                  a_neg, b_neg;
    logic [DATA_WIDTH-1:0] a_abs, b_abs;
    logic                  req_div_zero;

    always_comb begin
        is_div = funct3[2];
        if (is_div) begin
            a_signed = ~funct3[0];
            b_signed = ~funct3[0];
        end else begin
            a_signed = (funct3[1:0] != 2'b11);
            b_signed = (funct3[1] == 1'b0);
        end
        a_neg        = a_signed & Read_data1[Msb];
        b_neg        = b_signed & Read_data2[Msb];
        a_abs        = a_neg ? (~Read_data1 + 1'b1) : Read_data1;
        b_abs        = b_neg ? (~Read_data2 + 1'b1) : Read_data2;
        req_div_zero = (Read_data2 == '0);
    end

    // One iteration of shift-add multiply and restoring divide.
    logic [DATA_WIDTH:0]   mul_sum;
    logic [DATA_WIDTH:0]   div_shift;
    logic [DATA_WIDTH+1:0] div_diff;
    logic [DATA_WIDTH-1:0] step_hi, step_lo;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opa_q} : '0);
        div_shift = {hi_q, lo_q[Msb]};
        div_diff  = {1'b0, div_shift} - {2'b00, opa_q};
        if (op_q[2]) begin
            if (!div_diff[DATA_WIDTH+1]) begin
                step_hi = div_diff[DATA_WIDTH-1:0];
                step_lo = {lo_q[Msb-1:0], 1'b1};
            end else begin
                step_hi = div_shift[DATA_WIDTH-1:0];
                step_lo = {lo_q[Msb-1:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[DATA_WIDTH:1];
            step_lo = {mul_sum[0], lo_q[Msb:1]};
        end
    end

    // Sign correction and output word selection.
    logic [2*DATA_WIDTH-1:0] prod_raw, prod_fix;
    logic [DATA_WIDTH-1:0]   quo_fix, rem_fix, fix_word;

    always_comb begin
        prod_raw = {hi_q, lo_q};
        prod_fix = neg_q ? (~prod_raw + 1'b1) : prod_raw;
        quo_fix  = neg_q ? (~lo_q + 1'b1) : lo_q;
        // With a zero divisor the restoring loop leaves |dividend| in hi, so the
        // sign-corrected remainder is already the dividend. Signed overflow also falls
        // out naturally: |0x80000000| / 1 = 0x80000000, negated back to itself, rem 0.
        rem_fix  = rem_neg_q ? (~hi_q + 1'b1) : hi_q;
        case (op_q)
            3'b000:         fix_word = prod_fix[DATA_WIDTH-1:0];
            3'b001, 3'b010,
            3'b011:         fix_word = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
            3'b100, 3'b101: fix_word = div_zero_q ? '1 : quo_fix;
            default:        fix_word = rem_fix;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        rd_d       = rd_q;
        opa_d      = opa_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        neg_d      = neg_q;
        rem_neg_d  = rem_neg_q;
        div_zero_d = div_zero_q;
        result_d   = result_q;
        rd_out_d   = rd_out_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                // start wins over a simultaneous abort in IDLE.
                if (start) begin
                    state_d    = StCalc;
                    cnt_d      = '0;
                    op_d       = funct3;
                    rd_d       = Rd_in;
                    hi_d       = '0;
                    opa_d      = is_div ? b_abs : a_abs;
                    lo_d       = is_div ? a_abs : b_abs;
                    neg_d      = is_div ? ((a_neg ^ b_neg) & ~req_div_zero) : (a_neg ^ b_neg);
                    rem_neg_d  = a_neg;
                    div_zero_d = req_div_zero;
                end
            end
            StCalc: begin
                if (abort) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    hi_d = step_hi;
                    lo_d = step_lo;
                    if (cnt_q == LastCnt) begin
                        state_d = StFix;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StFix: begin
                state_d = StIdle;
                if (!abort) begin
                    result_d = fix_word;
                    rd_out_d = rd_q;
                    done_d   = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            op_q       <= '0;
            rd_q       <= '0;
            opa_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            result_q   <= '0;
            rd_out_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            opa_q      <= opa_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            neg_q      <= neg_d;
            rem_neg_q  <= rem_neg_d;
            div_zero_q <= div_zero_d;
            result_q   <= result_d;
            rd_out_q   <= rd_out_d;
            done_q     <= done_d;
        end
    end

    assign busy         = (state_q != StIdle);
    assign done         = done_q;
    assign RegWrite_out = done_q;
    assign Result       = result_q;
    assign Rd_out       = rd_out_q;

endmodule
